seq_mult_param: RTL



---
 rtl/seq_mult_param.sv | 64 ++++++
 1 files changed

// File: rtl/seq_mult_param.sv
// seq_mult_param: radix-2 shift-add sequential multiplier with a start/busy/done handshake.
// Defining SEQMUL_EARLY_TERM_EN ends RUN as soon as the remaining multiplier bits are all zero.
module seq_mult_param #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 signed_mode,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);
  localparam int CW = $clog2(WIDTH);
  typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;
  state_t state, state_n;
  logic [2*WIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0] mult, a_mag, b_mag;
  logic [CW-1:0] count;
  logic neg, last;
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
`ifdef SEQMUL_EARLY_TERM_EN
    last = (count == CW'(WIDTH-1)) || ((mult >> 1) == '0);
`else
    last = count == CW'(WIDTH-1);
`endif
    state_n = state == IDLE ? (start ? RUN : IDLE) :
              state == RUN  ? (last ? FIN : RUN) : IDLE;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      done    <= 1'b0;
      product <= '0;
      acc     <= '0;
      mcand   <= '0;
      mult    <= '0;
      count   <= '0;
      neg     <= 1'b0;
    end else begin
      state <= state_n;
      done  <= state == FIN;
      if (state == IDLE && start) begin
        mcand <= {{WIDTH{1'b0}}, a_mag};
        mult  <= b_mag;
        neg   <= signed_mode && (a[WIDTH-1] ^ b[WIDTH-1]);
        acc   <= '0;
        count <= '0;
      end
      if (state == RUN) begin
        if (mult[0]) acc <= acc + mcand;
        mcand <= mcand << 1;
        mult  <= mult >> 1;
        count <= count + 1'b1;
      end
      if (state == FIN) product <= neg ? -acc : acc;
    end
  end
endmodule
